// File: rtl/edf_irq_sequencer.sv
// rtl/edf_irq_sequencer.sv - EDF interrupt sequencer: preemption decision, core offer/claim, nesting stack, deadline-miss flag
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   mtime_i                       machine timer (low TsWidth bits compared against deadlines)
//   irq_valid_i/irq_id_i/irq_dl_i arbitration winner from the controller
//   irq_ack_o/irq_ack_id_o        one-cycle claim back to the controller
//   irq_req_o/irq_id_o            interrupt offered to the core
//   core_ack_i                    core takes the current offer
//   core_done_i                   core finished the handler at the top of the stack
//   run_valid_o/run_id_o/run_dl_o top-of-stack handler (decoded straight from the stack)
//   depth_o                       stack occupancy
//   dl_miss_o                     one-cycle pulse when the top handler passes its deadline
//   done_err_o                    one-cycle pulse when core_done_i arrives with an empty stack
module edf_irq_sequencer #(
    parameter int NrIrqs    = 4,
    parameter int TsWidth   = 24,
    parameter int NestDepth = 4,
    localparam int IdWidth  = $clog2(NrIrqs),
    localparam int DpWidth  = $clog2(NestDepth + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [63:0]        mtime_i,
    input  logic               irq_valid_i,
    input  logic [IdWidth-1:0] irq_id_i,
    input  logic [TsWidth-1:0] irq_dl_i,
    output logic               irq_ack_o,
    output logic [IdWidth-1:0] irq_ack_id_o,
    output logic               irq_req_o,
    output logic [IdWidth-1:0] irq_id_o,
    input  logic               core_ack_i,
    input  logic               core_done_i,
    output logic               run_valid_o,
    output logic [IdWidth-1:0] run_id_o,
    output logic [TsWidth-1:0] run_dl_o,
    output logic [DpWidth-1:0] depth_o,
    output logic               dl_miss_o,
    output logic               done_err_o
);

    localparam int IxWidth = (NestDepth > 1) ? $clog2(NestDepth) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_CLAIM
    } state_e;

    // Wrap-safe ordering: a is earlier than b when (a - b) is negative mod 2^TsWidth.
    function automatic logic earlier(input logic [TsWidth-1:0] a, input logic [TsWidth-1:0] b);
        logic [TsWidth-1:0] diff;
        diff = a - b;
        return diff[TsWidth-1];
    endfunction

    state_e               state_q, state_d;
    logic [IdWidth-1:0]   lat_id_q, lat_id_d;
    logic [TsWidth-1:0]   lat_dl_q, lat_dl_d;

    logic [IdWidth-1:0]   stk_id_q [NestDepth];
    logic [TsWidth-1:0]   stk_dl_q [NestDepth];
    logic [NestDepth-1:0] stk_miss_q;
    logic [DpWidth-1:0]   depth_q, depth_popped, depth_d;

    logic [IxWidth-1:0]   top_idx, push_idx;
    logic                 stack_empty, stack_full;
    logic [IdWidth-1:0]   top_id;
    logic [TsWidth-1:0]   top_dl;
    logic                 top_miss;
    logic                 eligible, pop, push, miss_hit, done_err;

    logic                 req_q, ack_q;
    logic [IdWidth-1:0]   req_id_q, ack_id_q;
    logic                 dl_miss_q, done_err_q;

    logic                 mtime_hi_unused;
    assign mtime_hi_unused = ^mtime_i[63:TsWidth];

    // ---------------------------------------------------------------
    // Stack decode
    // ---------------------------------------------------------------
    assign stack_empty = (depth_q == '0);
    assign stack_full  = (depth_q == DpWidth'(NestDepth));
    assign top_idx     = IxWidth'(depth_q - DpWidth'(1));
    assign top_id      = stack_empty ? '0 : stk_id_q[top_idx];
    assign top_dl      = stack_empty ? '0 : stk_dl_q[top_idx];
    assign top_miss    = stack_empty ? 1'b0 : stk_miss_q[top_idx];

    // A winner may only interrupt the running handler with a strictly earlier deadline.
    assign eligible = irq_valid_i &
                      (stack_empty | (!stack_full & earlier(irq_dl_i, top_dl)));

    // Pop happens before push, so a done in the claim cycle replaces the top entry.
    assign pop          = core_done_i & !stack_empty;
    assign done_err     = core_done_i & stack_empty;
    assign push         = (state_q == ST_CLAIM);
    assign depth_popped = depth_q - DpWidth'(pop);
    assign push_idx     = IxWidth'(depth_popped);
    assign depth_d      = depth_popped + DpWidth'(push);

    // Each entry reports its miss once; the flag lives with the entry.
    assign miss_hit = !stack_empty & !top_miss & !earlier(mtime_i[TsWidth-1:0], top_dl);

    // ---------------------------------------------------------------
    // Offer/claim FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            lat_id_q <= '0;
            lat_dl_q <= '0;
        end else begin
            state_q  <= state_d;
            lat_id_q <= lat_id_d;
            lat_dl_q <= lat_dl_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lat_id_d = lat_id_q;
        lat_dl_d = lat_dl_q;
        unique case (state_q)
            ST_IDLE: begin
                if (eligible) begin
                    lat_id_d = irq_id_i;
                    lat_dl_d = irq_dl_i;
                    state_d  = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (core_ack_i) begin
                    // The core took what it saw; keep the latched winner.
                    state_d = ST_CLAIM;
                end else if (pop) begin
                    // Top changed underneath the offer; re-decide from IDLE.
                    state_d = ST_IDLE;
                end else if (eligible) begin
                    lat_id_d = irq_id_i;
                    lat_dl_d = irq_dl_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLAIM: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Registered outputs, derived from the next state
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q      <= 1'b0;
            req_id_q   <= '0;
            ack_q      <= 1'b0;
            ack_id_q   <= '0;
            dl_miss_q  <= 1'b0;
            done_err_q <= 1'b0;
        end else begin
            req_q      <= (state_d == ST_OFFER);
            req_id_q   <= (state_d == ST_OFFER) ? lat_id_d : '0;
            ack_q      <= (state_d == ST_CLAIM);
            ack_id_q   <= (state_d == ST_CLAIM) ? lat_id_d : '0;
            dl_miss_q  <= miss_hit;
            done_err_q <= done_err;
        end
    end

    // ---------------------------------------------------------------
    // Nesting stack
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            depth_q    <= '0;
            stk_miss_q <= '0;
            for (int i = 0; i < NestDepth; i++) begin
                stk_id_q[i] <= '0;
                stk_dl_q[i] <= '0;
            end
        end else begin
            if (miss_hit) begin
                stk_miss_q[top_idx] <= 1'b1;
            end
            if (push) begin
                stk_id_q[push_idx]   <= lat_id_q;
                stk_dl_q[push_idx]   <= lat_dl_q;
                stk_miss_q[push_idx] <= 1'b0;
            end
            depth_q <= depth_d;
        end
    end

    assign irq_req_o    = req_q;
    assign irq_id_o     = req_id_q;
    assign irq_ack_o    = ack_q;
    assign irq_ack_id_o = ack_id_q;
    assign dl_miss_o    = dl_miss_q;
    assign done_err_o   = done_err_q;
    assign run_valid_o  = !stack_empty;
    assign run_id_o     = top_id;
    assign run_dl_o     = top_dl;
    assign depth_o      = depth_q;

endmodule

// File: tb/tb_edf_irq_sequencer.sv
// tb/tb_edf_irq_sequencer.sv - directed self-checking bench for edf_irq_sequencer
module tb_edf_irq_sequencer;

    localparam int NR = 4;
    localparam int TS = 24;
    localparam int ND = 2;

    logic          clk;
    logic          rst_n;
    logic [63:0]   mtime;
    logic          irq_valid;
    logic [1:0]    irq_id;
    logic [TS-1:0] irq_dl;
    logic          irq_ack;
    logic [1:0]    irq_ack_id;
    logic          irq_req;
    logic [1:0]    irq_id_out;
    logic          core_ack;
    logic          core_done;
    logic          run_valid;
    logic [1:0]    run_id;
    logic [TS-1:0] run_dl;
    logic [1:0]    depth;
    logic          dl_miss;
    logic          done_err;

    int checks = 0;
    int passed = 0;

    edf_irq_sequencer #(
        .NrIrqs   (NR),
        .TsWidth  (TS),
        .NestDepth(ND)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .mtime_i     (mtime),
        .irq_valid_i (irq_valid),
        .irq_id_i    (irq_id),
        .irq_dl_i    (irq_dl),
        .irq_ack_o   (irq_ack),
        .irq_ack_id_o(irq_ack_id),
        .irq_req_o   (irq_req),
        .irq_id_o    (irq_id_out),
        .core_ack_i  (core_ack),
        .core_done_i (core_done),
        .run_valid_o (run_valid),
        .run_id_o    (run_id),
        .run_dl_o    (run_dl),
        .depth_o     (depth),
        .dl_miss_o   (dl_miss),
        .done_err_o  (done_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: offer, accept and claim a winner, leaving the FSM in IDLE.
    task automatic push_irq(input logic [1:0] id, input logic [TS-1:0] dl);
        irq_valid = 1'b1; irq_id = id; irq_dl = dl;
        tick();
        core_ack = 1'b1;
        tick();
        core_ack = 1'b0; irq_valid = 1'b0;
        tick();
    endtask

    task automatic pop_irq();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mtime = '0; irq_valid = 1'b0; irq_id = '0; irq_dl = '0;
        core_ack = 1'b0; core_done = 1'b0;
        tick(); tick();
        checks++; if ({irq_req, irq_ack, irq_ack_id, irq_id_out, dl_miss, done_err} !== '0)
            $display("FAIL reset_outs got=%0h exp=0", {irq_req, irq_ack, irq_ack_id, irq_id_out, dl_miss, done_err}); else passed++;
        checks++; if ({run_valid, run_id, run_dl, depth} !== '0)
            $display("FAIL reset_stack got=%0h exp=0", {run_valid, run_id, run_dl, depth}); else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        irq_valid = 1'b1; irq_id = 2'd2; irq_dl = 24'd100;
        tick();
        checks++; if (irq_req !== 1'b1 || irq_id_out !== 2'd2)
            $display("FAIL single_req got=%0b/%0d exp=1/2", irq_req, irq_id_out); else passed++;
        tick();
        core_ack = 1'b1;
        tick();
        checks++; if (irq_ack !== 1'b1 || irq_ack_id !== 2'd2 || irq_req !== 1'b0)
            $display("FAIL single_ack got=%0b/%0d/%0b exp=1/2/0", irq_ack, irq_ack_id, irq_req); else passed++;
        checks++; if (depth !== 2'd0)
            $display("FAIL single_depth_early got=%0d exp=0", depth); else passed++;
        core_ack = 1'b0; irq_valid = 1'b0;
        tick();
        checks++; if (depth !== 2'd1 || run_id !== 2'd2 || run_dl !== 24'd100 || run_valid !== 1'b1)
            $display("FAIL single_push got=%0d/%0d/%0d exp=1/2/100", depth, run_id, run_dl); else passed++;
        checks++; if (irq_ack !== 1'b0)
            $display("FAIL single_ack_pulse got=%0b exp=0", irq_ack); else passed++;
        pop_irq();
        checks++; if (depth !== 2'd0 || run_valid !== 1'b0)
            $display("FAIL single_pop got=%0d exp=0", depth); else passed++;
    endtask

    task automatic test_preempt();
        push_irq(2'd1, 24'd500);
        irq_valid = 1'b1; irq_id = 2'd3; irq_dl = 24'd700;
        tick(); tick();
        checks++; if (irq_req !== 1'b0)
            $display("FAIL preempt_later got=%0b exp=0", irq_req); else passed++;
        irq_dl = 24'd500;
        tick(); tick();
        checks++; if (irq_req !== 1'b0)
            $display("FAIL preempt_tie got=%0b exp=0", irq_req); else passed++;
        irq_dl = 24'd300;
        tick();
        checks++; if (irq_req !== 1'b1 || irq_id_out !== 2'd3)
            $display("FAIL preempt_offer got=%0b/%0d exp=1/3", irq_req, irq_id_out); else passed++;
        core_ack = 1'b1;
        tick();
        core_ack = 1'b0; irq_valid = 1'b0;
        checks++; if (irq_ack !== 1'b1 || irq_ack_id !== 2'd3)
            $display("FAIL preempt_ack got=%0b/%0d exp=1/3", irq_ack, irq_ack_id); else passed++;
        tick();
        checks++; if (depth !== 2'd2 || run_id !== 2'd3 || run_dl !== 24'd300)
            $display("FAIL preempt_push got=%0d/%0d/%0d exp=2/3/300", depth, run_id, run_dl); else passed++;
        pop_irq();
        checks++; if (depth !== 2'd1 || run_id !== 2'd1 || run_dl !== 24'd500)
            $display("FAIL preempt_pop got=%0d/%0d/%0d exp=1/1/500", depth, run_id, run_dl); else passed++;
        pop_irq();
    endtask

    task automatic test_wrap();
        push_irq(2'd0, 24'h000010);
        irq_valid = 1'b1; irq_id = 2'd1; irq_dl = 24'h000020;
        tick();
        checks++; if (irq_req !== 1'b0)
            $display("FAIL wrap_later got=%0b exp=0", irq_req); else passed++;
        irq_dl = 24'hFFFFF0;
        tick();
        checks++; if (irq_req !== 1'b1 || irq_id_out !== 2'd1)
            $display("FAIL wrap_offer got=%0b/%0d exp=1/1", irq_req, irq_id_out); else passed++;
        irq_valid = 1'b0;
        tick();
        checks++; if (irq_req !== 1'b0 || depth !== 2'd1)
            $display("FAIL wrap_withdraw got=%0b/%0d exp=0/1", irq_req, depth); else passed++;
        pop_irq();
    endtask

    task automatic test_full();
        push_irq(2'd1, 24'd500);
        push_irq(2'd2, 24'd300);
        checks++; if (depth !== 2'd2 || run_id !== 2'd2)
            $display("FAIL full_depth got=%0d/%0d exp=2/2", depth, run_id); else passed++;
        irq_valid = 1'b1; irq_id = 2'd3; irq_dl = 24'd100;
        tick(); tick();
        checks++; if (irq_req !== 1'b0)
            $display("FAIL full_no_offer got=%0b exp=0", irq_req); else passed++;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        checks++; if (depth !== 2'd1 || run_id !== 2'd1 || irq_req !== 1'b0)
            $display("FAIL full_pop got=%0d/%0d/%0b exp=1/1/0", depth, run_id, irq_req); else passed++;
        tick();
        checks++; if (irq_req !== 1'b1 || irq_id_out !== 2'd3)
            $display("FAIL full_offer got=%0b/%0d exp=1/3", irq_req, irq_id_out); else passed++;
        irq_valid = 1'b0;
        tick();
        pop_irq();
    endtask

    task automatic test_miss();
        int pulses;
        pulses = 0;
        mtime = 64'd990;
        push_irq(2'd1, 24'd1000);
        for (int m = 990; m <= 1010; m++) begin
            mtime = 64'(m);
            tick();
            if (dl_miss === 1'b1) pulses++;
            if (m == 1000) begin
                checks++; if (dl_miss !== 1'b1)
                    $display("FAIL miss_at_dl got=%0b exp=1", dl_miss); else passed++;
            end
        end
        checks++; if (pulses !== 1)
            $display("FAIL miss_pulse_count got=%0d exp=1", pulses); else passed++;
        pop_irq();
        mtime = '0;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        checks++; if (done_err !== 1'b1 || depth !== 2'd0)
            $display("FAIL done_err got=%0b/%0d exp=1/0", done_err, depth); else passed++;
        tick();
        checks++; if (done_err !== 1'b0)
            $display("FAIL done_err_pulse got=%0b exp=0", done_err); else passed++;
    endtask

    task automatic test_back_to_back();
        push_irq(2'd1, 24'd500);
        irq_valid = 1'b1; irq_id = 2'd2; irq_dl = 24'd200;
        tick();
        core_ack = 1'b1;
        tick();
        core_ack = 1'b0; irq_valid = 1'b0; core_done = 1'b1;
        checks++; if (irq_ack !== 1'b1 || irq_ack_id !== 2'd2)
            $display("FAIL simul_ack got=%0b/%0d exp=1/2", irq_ack, irq_ack_id); else passed++;
        tick();
        core_done = 1'b0;
        checks++; if (depth !== 2'd1 || run_id !== 2'd2 || run_dl !== 24'd200)
            $display("FAIL simul_replace got=%0d/%0d/%0d exp=1/2/200", depth, run_id, run_dl); else passed++;
        pop_irq();
    endtask

    task automatic test_reset_offer();
        push_irq(2'd1, 24'd500);
        irq_valid = 1'b1; irq_id = 2'd2; irq_dl = 24'd300;
        tick();
        checks++; if (irq_req !== 1'b1)
            $display("FAIL rst_pre_offer got=%0b exp=1", irq_req); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({irq_req, irq_id_out, irq_ack, dl_miss, done_err} !== '0)
            $display("FAIL rst_async_outs got=%0h exp=0", {irq_req, irq_id_out, irq_ack, dl_miss, done_err}); else passed++;
        checks++; if ({run_valid, run_id, run_dl, depth} !== '0)
            $display("FAIL rst_async_stack got=%0h exp=0", {run_valid, run_id, run_dl, depth}); else passed++;
        irq_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_preempt();
        test_wrap();
        test_full();
        test_miss();
        test_back_to_back();
        test_reset_offer();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
